// File: rtl/alu_issue_ctrl.sv
// Serial issue controller for an external combinational ALU: decode, operand read, execute, writeback.
// Optional ALU_PERF_EN macro adds a saturating 16-bit completed-op counter (perf_ops).
module alu_issue_ctrl #(
  parameter int DATA_W   = 20,
  parameter int INSTR_W  = 14,
  parameter int NUM_REGS = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [INSTR_W-1:0] instr,
  output logic [INSTR_W-1:0] alu_instruction,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  input  logic [DATA_W-1:0]  alu_result,
  output logic               done_valid,
  output logic [2:0]         done_rd,
  output logic [DATA_W-1:0]  done_data,
  input  logic               ext_wr_en,
  input  logic [2:0]         ext_wr_addr,
  input  logic [DATA_W-1:0]  ext_wr_data,
  output logic               ext_wr_ready,
  input  logic [2:0]         dbg_addr,
  output logic [DATA_W-1:0]  dbg_data
`ifdef ALU_PERF_EN
  ,
  output logic [15:0]        perf_ops
`endif
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [INSTR_W-1:0]  instr_q;
  logic [DATA_W-1:0]   a_q, b_q, data_q;
  logic [2:0]          rd_q;
  logic [2:0]          rd, rs1, rs2;
  logic [DATA_W-1:0]   rs1_val, rs2_val;
  logic                accept, ext_commit;

  assign rd  = instr_q[9:7];
  assign rs1 = instr_q[6:4];
  assign rs2 = instr_q[3:1];

  // r0 reads as zero regardless of storage
  assign rs1_val  = (rs1 == 3'd0) ? '0 : regs_q[rs1];
  assign rs2_val  = (rs2 == 3'd0) ? '0 : regs_q[rs2];
  assign dbg_data = (dbg_addr == 3'd0) ? '0 : regs_q[dbg_addr];

  assign instr_ready     = (state_q == IDLE);
  assign ext_wr_ready    = (state_q == IDLE);
  assign accept          = instr_valid & instr_ready;
  assign ext_commit      = ext_wr_en & ext_wr_ready;
  assign done_valid      = (state_q == WB);
  assign done_rd         = rd_q;
  assign done_data       = data_q;
  assign alu_instruction = instr_q;
  assign alu_a           = a_q;
  assign alu_b           = b_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WB;
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      if (accept) instr_q <= instr;
      if (state_q == READ) begin
        a_q <= rs1_val;
        b_q <= rs2_val;
      end
      // data_q doubles as the result register and the held done_data
      if (state_q == EXEC) begin
        rd_q   <= rd;
        data_q <= alu_result;
      end
    end
  end

  // External writes only land in IDLE and writeback only in WB, so they never collide
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (ext_commit) begin
      if (ext_wr_addr != 3'd0) regs_q[ext_wr_addr] <= ext_wr_data;
    end else if (state_q == WB) begin
      if (rd_q != 3'd0) regs_q[rd_q] <= data_q;
    end
  end

`ifdef ALU_PERF_EN
  logic [15:0] perf_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                 perf_q <= '0;
    else if (done_valid && perf_q != 16'hFFFF) perf_q <= perf_q + 16'd1;
  end
  assign perf_ops = perf_q;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with an adder standing in for the ALU.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready;
  logic [13:0] instr, alu_instruction;
  logic [19:0] alu_a, alu_b, alu_result;
  logic        done_valid;
  logic [2:0]  done_rd;
  logic [19:0] done_data;
  logic        ext_wr_en, ext_wr_ready;
  logic [2:0]  ext_wr_addr, dbg_addr;
  logic [19:0] ext_wr_data, dbg_data;
`ifdef ALU_PERF_EN
  logic [15:0] perf_ops;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;
  assign alu_result = alu_a + alu_b;

  alu_issue_ctrl dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_instruction(alu_instruction), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result),
    .done_valid(done_valid), .done_rd(done_rd), .done_data(done_data),
    .ext_wr_en(ext_wr_en), .ext_wr_addr(ext_wr_addr), .ext_wr_data(ext_wr_data),
    .ext_wr_ready(ext_wr_ready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
`ifdef ALU_PERF_EN
    , .perf_ops(perf_ops)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dbg_chk(input string tag, input logic [2:0] a, input logic [19:0] exp);
    dbg_addr = a;
    #1;
    chk(tag, 32'(dbg_data), 32'(exp));
  endtask

  task automatic ext_wr(input logic [2:0] a, input logic [19:0] d);
    ext_wr_en = 1'b1; ext_wr_addr = a; ext_wr_data = d;
    step();
    ext_wr_en = 1'b0;
  endtask

  function automatic logic [13:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                     input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 1'b0};
  endfunction

  // Issue from IDLE and walk READ, EXEC, WB back to IDLE
  task automatic run_op(input string tag, input logic [13:0] ins, input logic [19:0] ea,
                        input logic [19:0] eb, input logic [2:0] erd, input logic [19:0] ed);
    chk({tag, ".rdy"}, 32'(instr_ready), 32'd1);
    instr_valid = 1'b1; instr = ins;
    step();
    instr_valid = 1'b0;
    chk({tag, ".ins"}, 32'(alu_instruction), 32'(ins));
    chk({tag, ".busy"}, 32'(instr_ready), 32'd0);
    chk({tag, ".early"}, 32'(done_valid), 32'd0);
    step();
    chk({tag, ".a"}, 32'(alu_a), 32'(ea));
    chk({tag, ".b"}, 32'(alu_b), 32'(eb));
    step();
    chk({tag, ".dv"}, 32'(done_valid), 32'd1);
    chk({tag, ".drd"}, 32'(done_rd), 32'(erd));
    chk({tag, ".dd"}, 32'(done_data), 32'(ed));
    step();
    chk({tag, ".dv0"}, 32'(done_valid), 32'd0);
    chk({tag, ".hold"}, 32'(done_data), 32'(ed));
  endtask

  initial begin
    rst = 1'b1; instr_valid = 1'b0; instr = '0;
    ext_wr_en = 1'b0; ext_wr_addr = '0; ext_wr_data = '0; dbg_addr = '0;
    step(); step();
    chk("rst.rdy", 32'(instr_ready), 32'd1);
    chk("rst.erdy", 32'(ext_wr_ready), 32'd1);
    chk("rst.a", 32'(alu_a), 32'd0);
    chk("rst.ins", 32'(alu_instruction), 32'd0);
    chk("rst.dv", 32'(done_valid), 32'd0);
    rst = 1'b0;
    step();

    // basic op
    ext_wr(3'd3, 20'h000AA);
    ext_wr(3'd5, 20'h00003);
    dbg_chk("pre.r3", 3'd3, 20'h000AA);
    run_op("basic", 14'h13A, 20'h000AA, 20'h00003, 3'd2, 20'h000AD);
    dbg_chk("basic.r2", 3'd2, 20'h000AD);

    // r0 hardwired zero
    ext_wr(3'd0, 20'h12345);
    dbg_chk("r0.ext", 3'd0, 20'h0);
    run_op("r0op", mk(4'h0, 3'd0, 3'd0, 3'd5), 20'h0, 20'h00003, 3'd0, 20'h00003);
    dbg_chk("r0.wb", 3'd0, 20'h0);

    // back-to-back dependency with instr_valid held
    instr_valid = 1'b1; instr = mk(4'h1, 3'd4, 3'd3, 3'd5);
    step();
    instr = mk(4'h2, 3'd6, 3'd4, 3'd5);
    for (int i = 0; i < 3; i++) begin
      chk("b2b.gap", 32'(instr_ready), 32'd0);
      step();
    end
    chk("b2b.rdy", 32'(instr_ready), 32'd1);
    step();
    instr_valid = 1'b0;
    chk("b2b.ins2", 32'(alu_instruction), 32'(mk(4'h2, 3'd6, 3'd4, 3'd5)));
    step();
    chk("b2b.a2", 32'(alu_a), 32'h000AD);
    step();
    chk("b2b.dd2", 32'(done_data), 32'h000B0);
    chk("b2b.drd2", 32'(done_rd), 32'd6);
    step();
    dbg_chk("b2b.r6", 3'd6, 20'h000B0);

    // simultaneous accept and ext write, then blocked ext write
    ext_wr_en = 1'b1; ext_wr_addr = 3'd3; ext_wr_data = 20'h00010;
    instr_valid = 1'b1; instr = mk(4'h0, 3'd7, 3'd3, 3'd5);
    step();
    ext_wr_en = 1'b0; instr_valid = 1'b0;
    step();
    chk("sim.a", 32'(alu_a), 32'h00010);
    ext_wr_en = 1'b1; ext_wr_addr = 3'd5; ext_wr_data = 20'h00777;
    #1;
    chk("blk.erdy", 32'(ext_wr_ready), 32'd0);
    step();
    dbg_chk("blk.r5a", 3'd5, 20'h00003);
    chk("sim.dd", 32'(done_data), 32'h00013);
    step();
    dbg_chk("blk.r5b", 3'd5, 20'h00003);
    step();
    ext_wr_en = 1'b0;
    dbg_chk("blk.r5c", 3'd5, 20'h00777);
    dbg_chk("sim.r7", 3'd7, 20'h00013);

    // 20-bit wrap
    ext_wr(3'd3, 20'hFFFFF);
    ext_wr(3'd5, 20'h00001);
    run_op("wrap", mk(4'h0, 3'd1, 3'd3, 3'd5), 20'hFFFFF, 20'h00001, 3'd1, 20'h00000);
`ifdef ALU_PERF_EN
    chk("perf.cnt", 32'(perf_ops), 32'd6);
`endif

    // reset mid-EXEC
    instr_valid = 1'b1; instr = mk(4'h0, 3'd2, 3'd3, 3'd5);
    step();
    instr_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("mrst.rdy", 32'(instr_ready), 32'd1);
    chk("mrst.a", 32'(alu_a), 32'd0);
    chk("mrst.b", 32'(alu_b), 32'd0);
    chk("mrst.dv", 32'(done_valid), 32'd0);
    dbg_chk("mrst.r3", 3'd3, 20'h0);
    dbg_chk("mrst.r6", 3'd6, 20'h0);
`ifdef ALU_PERF_EN
    chk("perf.clr", 32'(perf_ops), 32'd0);
`endif
    step();
    rst = 1'b0;
    step();
    chk("mrst.dv2", 32'(done_valid), 32'd0);
    chk("mrst.erdy", 32'(ext_wr_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencing controller for the 20-bit combinational ALU. Accepts 14-bit instructions over a valid/ready handshake and decodes register fields. Reads operands from an internal 8x20 register file, drives the ALU instruction/A/B inputs, captures the ALU result and writes it back. Sits between the instruction source and the ALU; the ALU itself stays external and purely combinational.

Parameters:
DATA_W, 20, operand/result width; must match the ALU.
INSTR_W, 14, instruction width; the field layout below requires 14.
NUM_REGS, 8, register file depth; address width fixed at 3.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept; high only in IDLE
instr  in  14  instruction word
alu_instruction  out  14  to ALU instruction port (latched instr)
alu_a  out  20  to ALU A
alu_b  out  20  to ALU B
alu_result  in  20  from ALU result
done_valid  out  1  one-cycle pulse, op written back
done_rd  out  3  destination register of completed op
done_data  out  20  value written
ext_wr_en  in  1  external register-file write (preload)
ext_wr_addr  in  3  external write address
ext_wr_data  in  20  external write data
ext_wr_ready  out  1  external write accepted this cycle; high only in IDLE
dbg_addr  in  3  debug read address
dbg_data  out  20  combinational read of regs[dbg_addr]

Behaviour:
- Instruction fields: [13:10] ALU op (not decoded here, forwarded whole); [9:7] rd; [6:4] rs1; [3:1] rs2; [0] ignored by controller.
- r0 is hardwired zero: reads return 0; writes to r0 (writeback or external) are discarded. done_valid still pulses for rd=0, with done_data = the ALU value.
- FSM: IDLE -> READ -> EXEC -> WB -> IDLE.
- IDLE: instr_ready=1. Handshake on instr_valid & instr_ready at the clock edge latches instr into alu_instruction; go to READ.
- READ: alu_a <= regs[rs1], alu_b <= regs[rs2]; go to EXEC.
- EXEC: ALU inputs stable for the full cycle. The result register <= alu_result at the end of the cycle; go to WB.
- WB: regs[rd] <= result. done_valid=1, done_rd=rd, done_data=result for exactly this cycle; go to IDLE.
- Latency: accept at edge N; done_valid high in cycle N+3. Throughput: one op per 4 cycles. No output backpressure.
- Ops are strictly serial, so READ always sees the previous op's writeback. No hazards.
- External write commits at an edge only when ext_wr_en & ext_wr_ready, i.e. in IDLE. It is ignored otherwise; the source must hold it until ext_wr_ready.
- Simultaneous accept and external write in IDLE: both take effect at that edge, and the following READ sees the new value.
- Arithmetic: the controller does none. Values are passed and stored at 20 bits, with no extension or truncation beyond DATA_W.
- Reset (any state, including mid-op): state=IDLE; all regs=0; alu_instruction=0, alu_a=0, alu_b=0; done_valid=0, done_rd=0, done_data=0. instr_ready=1 and ext_wr_ready=1 while in IDLE, including during reset. An in-flight op is discarded with no done pulse.
- done_rd/done_data hold their last values outside WB; only done_valid qualifies them.

Optional Feature:
ALU_PERF_EN: when defined, adds output perf_ops [15:0]. It increments on every done_valid and saturates at 0xFFFF, and is cleared by rst. When not defined, the port and counter are absent.

Test Plan:
- Reset: assert rst mid-EXEC -> next cycle state IDLE, instr_ready=1, alu_a=alu_b=0, all regs 0, no done_valid pulse.
- Basic op (bench ALU stub: alu_result=alu_a+alu_b mod 2^20): ext-write r3=0x000AA, r5=0x00003; issue instr=0x13A (rd=2, rs1=3, rs2=5) at edge N. Expect alu_instruction=0x13A, alu_a=0xAA, alu_b=0x3 in EXEC; done_valid in cycle N+3 with done_rd=2, done_data=0x000AD; dbg_addr=2 -> 0x000AD.
- r0 rules: ext-write r0=0x12345 -> dbg r0=0. Issue op with rd=0, rs1=0, rs2=5 (r5=3) -> alu_a=0, done_data=0x3, done_rd=0, r0 still 0.
- Back-to-back dependency: hold instr_valid high with two ops, the second reading rd of the first. Second accepted exactly 4 cycles after the first; instr_ready low for 3 cycles in between; second alu_a equals the first's result.
- Simultaneous/blocked writes: ext write r3=0x00010 in the same IDLE cycle an op reading r3 is accepted -> alu_a=0x00010. Ext write attempted during EXEC -> ext_wr_ready=0, register unchanged until IDLE.
- Wrap and perf: r3=0xFFFFF, r5=0x00001 -> done_data=0x00000. With ALU_PERF_EN, perf_ops counts 1 per done pulse, and after 65536+ ops holds 0xFFFF.
